// File: rtl/mem_bus_interface_pkg.sv
// Shared types and defaults for the memory-access unit (MAR/MDR + request/ack handshake).
package mem_if_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_ADDR_W  = 9;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Width needed to count 0..timeout inclusive.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bus_interface_if.sv
// Bus-side and memory-side signals of the memory-access unit, grouped as one interface.
interface mem_bus_if
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic [DATA_W-1:0] bus_in;
    logic              mar_in;
    logic              mdr_in;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] mdr_out;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  bus_in, mar_in, mdr_in, read, write, mem_ack, mem_rdata,
        output mdr_out, busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output bus_in, mar_in, mdr_in, read, write, mem_ack, mem_rdata,
        input  mdr_out, busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_interface_timeout_counter.sv
// Wait-state counter for one memory access; flags the last permitted cycle before abort.
module mem_timeout_counter
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic clock,
    input  logic clear,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_expired
);
    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_bus_interface.sv
// MAR/MDR front end with a request/acknowledge handshake to variable-latency memory,
// including timeout, address range check and done/err reporting.
module mem_bus_interface
    import mem_if_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter bit STRICT_ADDR = 1'b1
) (
    input  logic     clock,
    input  logic     clear,
    mem_bus_if.slave bus
);
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_err;

    logic w_in_idle;
    logic w_in_access;
    logic w_start;
    logic w_collide;
    logic w_range_err;
    logic w_issue;
    logic w_reject;
    logic w_ack;
    logic w_abort;
    logic w_expired;

    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_start     = bus.read ^ bus.write;
    assign w_collide   = bus.read & bus.write;
    assign w_range_err = STRICT_ADDR && ((r_mar >> ADDR_W) != '0);
    assign w_issue     = w_in_idle && w_start && !w_range_err;
    assign w_reject    = w_in_idle && (w_collide || (w_start && w_range_err));
    assign w_ack       = w_in_access && bus.mem_ack;
    assign w_abort     = w_in_access && !bus.mem_ack && w_expired;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .clear     (clear),
        .i_restart (w_issue),
        .i_enable  (w_in_access && !bus.mem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: defaulting w_next before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_reject) begin
                    w_next = ST_FINISH;
                end else if (w_issue) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_ack || w_abort) begin
                    w_next = ST_FINISH;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = w_in_access;
        bus.done = (r_state == ST_FINISH);
    end

    // NOTE: MAR/MDR are ordinary registers, not a RAM array, so they take the async reset too.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_mar      <= '0;
            r_mdr      <= '0;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (!w_in_access && bus.mar_in) begin
                r_mar <= bus.bus_in;
            end

            if (w_ack && !r_mem_we) begin
                r_mdr <= bus.mem_rdata;
            end else if (!w_in_access && bus.mdr_in) begin
                r_mdr <= bus.bus_in;
            end

            // Address and write data come from the pre-edge MAR/MDR, so a same-cycle load cannot race the start.
            if (w_issue) begin
                r_mem_addr <= r_mar[ADDR_W-1:0];
                r_mem_we   <= bus.write;
                r_wdata    <= r_mdr;
            end

            if (w_issue) begin
                r_mem_req <= 1'b1;
            end else if (w_ack || w_abort) begin
                r_mem_req <= 1'b0;
            end

            if (w_issue || w_ack) begin
                r_err <= 1'b0;
            end else if (w_reject || w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mdr_out   = r_mdr;
    assign bus.err       = r_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_bus_interface.sv
// Self-checking bench: directed cases plus randomized transactions scored against a transaction-level model.
module tb_mem_bus_interface;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 4;

    logic clock;
    logic clear;
    int   n_checks;
    int   n_errors;

    // Model of the architecturally visible registers
    logic [DATA_W-1:0] m_mar;
    logic [DATA_W-1:0] m_mdr;
    logic              m_err;

    mem_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
    mem_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

    mem_bus_interface #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .STRICT_ADDR(1'b1)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_a.slave)
    );

    mem_bus_interface #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .STRICT_ADDR(1'b0)
    ) dut_loose (
        .clock (clock),
        .clear (clear),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_a.mar_in  = 1'b0;
        bus_a.mdr_in  = 1'b0;
        bus_a.read    = 1'b0;
        bus_a.write   = 1'b0;
        bus_a.mem_ack = 1'b0;
    endtask

    // op: 0 read, 1 write, 2 read+write. lat: edge at which ack arrives (lat > TIMEOUT means never).
    task automatic do_txn(input int op, input int lat, input logic [DATA_W-1:0] mar_v,
                          input logic [DATA_W-1:0] mdr_v, input logic [DATA_W-1:0] rdata_v,
                          input bit noise, input bit overlap);
        logic [DATA_W-1:0] old_mar;
        logic [DATA_W-1:0] old_mdr;
        logic [DATA_W-1:0] new_v;
        bit                rejected;
        int                n;

        bus_a.mar_in = 1'b1;
        bus_a.bus_in = mar_v;
        @(negedge clock);
        m_mar = mar_v;
        bus_a.mar_in = 1'b0;
        bus_a.mdr_in = 1'b1;
        bus_a.bus_in = mdr_v;
        @(negedge clock);
        m_mdr = mdr_v;
        bus_a.mdr_in = 1'b0;
        check("mdr_load", bus_a.mdr_out, m_mdr);

        old_mar = m_mar;
        old_mdr = m_mdr;
        bus_a.read  = (op != 1);
        bus_a.write = (op != 0);
        new_v = $urandom;
        if (overlap) begin
            bus_a.bus_in = new_v;
            bus_a.mar_in = 1'b1;
            bus_a.mdr_in = 1'b1;
        end
        @(negedge clock);
        idle_inputs();
        if (overlap) begin
            m_mar = new_v;
            m_mdr = new_v;
        end

        rejected = (op == 2) || ((old_mar >> ADDR_W) != 0);
        if (!rejected) begin
            n = (lat <= TIMEOUT) ? lat : TIMEOUT;
            for (int e = 1; e <= n; e++) begin
                check("acc_req", bus_a.mem_req, 1);
                check("acc_busy", bus_a.busy, 1);
                check("acc_done", bus_a.done, 0);
                check("acc_addr", bus_a.mem_addr, old_mar % (1 << ADDR_W));
                check("acc_we", bus_a.mem_we, (op == 1));
                if (op == 1) check("acc_wdata", bus_a.mem_wdata, old_mdr);
                check("acc_mdr_stable", bus_a.mdr_out, m_mdr);
                if (e == lat) begin
                    bus_a.mem_ack   = 1'b1;
                    bus_a.mem_rdata = rdata_v;
                end
                if (noise) begin
                    bus_a.read   = 1'b1;
                    bus_a.mar_in = 1'b1;
                    bus_a.mdr_in = 1'b1;
                    bus_a.bus_in = $urandom;
                end
                @(negedge clock);
                idle_inputs();
            end
            if (lat <= TIMEOUT) begin
                m_err = 1'b0;
                if (op == 0) m_mdr = rdata_v;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_err = 1'b1;
        end

        check("fin_done", bus_a.done, 1);
        check("fin_busy", bus_a.busy, 0);
        check("fin_req", bus_a.mem_req, 0);
        check("fin_err", bus_a.err, m_err);
        check("fin_mdr", bus_a.mdr_out, m_mdr);
        if (noise) begin
            bus_a.read      = 1'b1;
            bus_a.mem_ack   = 1'b1;
            bus_a.mem_rdata = $urandom;
        end
        @(negedge clock);
        idle_inputs();
        check("idle_done", bus_a.done, 0);
        check("idle_busy", bus_a.busy, 0);
        check("idle_req", bus_a.mem_req, 0);
        check("idle_err", bus_a.err, m_err);
        check("idle_mdr", bus_a.mdr_out, m_mdr);

        if (noise) begin
            bus_a.mem_ack   = 1'b1;
            bus_a.mem_rdata = $urandom;
            @(negedge clock);
            idle_inputs();
            check("stray_ack_mdr", bus_a.mdr_out, m_mdr);
            check("stray_ack_busy", bus_a.busy, 0);
            check("stray_ack_done", bus_a.done, 0);
        end
    endtask

    initial begin
        int                op;
        logic [DATA_W-1:0] mar_v;

        n_checks = 0;
        n_errors = 0;
        m_mar = '0;
        m_mdr = '0;
        m_err = 1'b0;
        clear = 1'b0;
        bus_a.bus_in = '0;
        bus_a.mem_rdata = '0;
        idle_inputs();
        bus_b.bus_in = '0;
        bus_b.mar_in = 1'b0;
        bus_b.mdr_in = 1'b0;
        bus_b.read = 1'b0;
        bus_b.write = 1'b0;
        bus_b.mem_ack = 1'b0;
        bus_b.mem_rdata = '0;

        repeat (2) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_err", bus_a.err, 0);
        check("rst_req", bus_a.mem_req, 0);
        check("rst_mdr", bus_a.mdr_out, 0);
        check("rst_addr", bus_a.mem_addr, 0);

        // Directed cases
        do_txn(0, 3, 32'h0000_0004, 32'h0000_0000, 32'h0000_00B6, 1'b0, 1'b0);
        do_txn(1, 1, 32'h0000_0087, 32'h1234_5678, 32'hAAAA_5555, 1'b0, 1'b0);
        do_txn(0, 6, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        do_txn(0, 1, 32'h0000_0200, 32'h0000_0033, 32'h0, 1'b0, 1'b0);
        do_txn(2, 1, 32'h0000_0010, 32'h0000_0044, 32'h0, 1'b0, 1'b0);
        do_txn(0, 2, 32'h0000_0020, 32'h0000_0055, 32'h0000_1234, 1'b1, 1'b0);
        do_txn(1, 2, 32'h0000_0021, 32'h0000_0066, 32'h0000_4321, 1'b0, 1'b1);

        // Reset asserted mid-access
        bus_a.mar_in = 1'b1;
        bus_a.bus_in = 32'h0000_0010;
        @(negedge clock);
        bus_a.mar_in = 1'b0;
        bus_a.read   = 1'b1;
        @(negedge clock);
        idle_inputs();
        check("rst_mid_pre_req", bus_a.mem_req, 1);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("rst_mid_req", bus_a.mem_req, 0);
        check("rst_mid_busy", bus_a.busy, 0);
        check("rst_mid_done", bus_a.done, 0);
        check("rst_mid_err", bus_a.err, 0);
        check("rst_mid_mdr", bus_a.mdr_out, 0);
        @(negedge clock);
        clear = 1'b1;
        m_mar = '0;
        m_mdr = '0;
        m_err = 1'b0;
        @(negedge clock);
        check("rst_rel_busy", bus_a.busy, 0);
        check("rst_rel_done", bus_a.done, 0);
        check("rst_rel_req", bus_a.mem_req, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            op = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            mar_v = DATA_W'($urandom_range(0, (1 << ADDR_W) - 1));
            if ($urandom_range(0, 3) == 0) mar_v = mar_v | (32'h1 << $urandom_range(ADDR_W, DATA_W - 1));
            do_txn(op, int'($urandom_range(1, 6)), mar_v, $urandom, $urandom,
                   bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        // Loose range check: upper MAR bits ignored
        @(negedge clock);
        bus_b.mar_in = 1'b1;
        bus_b.bus_in = 32'h0000_0200;
        @(negedge clock);
        bus_b.mar_in = 1'b0;
        bus_b.read   = 1'b1;
        @(negedge clock);
        bus_b.read = 1'b0;
        check("loose_req", bus_b.mem_req, 1);
        check("loose_addr", bus_b.mem_addr, 0);
        bus_b.mem_ack   = 1'b1;
        bus_b.mem_rdata = 32'h0000_0055;
        @(negedge clock);
        bus_b.mem_ack = 1'b0;
        check("loose_done", bus_b.done, 1);
        check("loose_err", bus_b.err, 0);
        check("loose_mdr", bus_b.mdr_out, 32'h0000_0055);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
